// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// 8N1 UART transmitter with a small byte FIFO in front of it. Framing is
// 1 start bit, 8 data bits sent LSB first, 1 stop bit, and no parity. It is
// timed to loop back into the matching UART receiver at the same
// BAUD_RATE / CLOCK_FREQ.
//
// A producer queues bytes over a valid/ready handshake. While one frame is on
// the wire, up to FIFO_DEPTH further bytes can wait. If a byte is queued when
// a stop bit ends, the next start bit follows on the very next cycle, with no
// idle gap between frames.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset (truncates any frame and
//                    drops every queued byte)
//   data_in     in   [7:0] byte to queue; sampled only on the push edge
//   data_valid  in   data_in is valid this cycle
//   data_ready  out  FIFO can accept a byte (fifo_count != FIFO_DEPTH)
//   tx          out  serial line, registered, idles high
//   busy        out  a frame is on the wire or the FIFO is non-empty
//   fifo_count  out  [$clog2(FIFO_DEPTH):0] bytes queued; the byte currently
//                    being shifted out is not counted
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int BAUD_RATE  = 9_600,
  parameter int CLOCK_FREQ = 48_000_000,
  parameter int FIFO_DEPTH = 4          // power of 2, >= 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  // The timer only ever holds values up to BIT_PERIOD-1.
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_nonempty;

  assign data_ready    = (count_q != DEPTH_C);
  assign fifo_push     = data_valid && data_ready;
  assign fifo_nonempty = (count_q != '0);

  // The storage is left unreset. Every entry is written before it is read,
  // and after a reset the cleared pointers make any stale contents
  // unreachable.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;   // idle, or push and pop cancel out
    endcase
  end

  // Because the depth is a power of 2, the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          timer_done;
  logic [2:0]    idx_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line value for the next cycle. Every bit-state therefore
  // loads the value of the state it is moving into, so tx changes on the same
  // edge as the state does.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    timer_done = (timer_q == '0);
    idx_inc    = idx_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          fifo_pop = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          timer_d  = TIMER_LOAD;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (timer_done) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          timer_d = TIMER_LOAD;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_DATA: begin
        if (timer_done) begin
          timer_d = TIMER_LOAD;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d = idx_inc;
            tx_d  = shift_q[idx_inc];
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_STOP: begin
        if (timer_done) begin
          if (fifo_nonempty) begin
            // Chain directly into the next start bit so that queued bytes
            // go out back-to-back.
            fifo_pop = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            timer_d  = TIMER_LOAD;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        // Recover from any corrupted encoding.
        state_d = S_IDLE;
        timer_d = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || fifo_nonempty;
  assign fifo_count = count_q;

endmodule
